// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch port and the
//   data load/store port. Grants round-robin, latches the transaction fields
//   for its whole duration, and returns one-cycle valid pulses. A watchdog
//   forces completion (read data 0, sticky err) if mem_ack never arrives.
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr                   fetch request (level) and address
//   if_rdata/if_valid                registered fetch data and its one-cycle pulse
//   d_req/d_we/d_addr/d_wdata/d_mode data request (level) and its fields
//   d_rdata/d_valid                  registered load data and completion pulse
//   stall                            combinational freeze for the core
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_mode               latched memory request fields
//   mem_rdata/mem_ack                memory read data and completion
//   err                              sticky watchdog-timeout flag
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_mode,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_mode,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  state_t               state, state_next;
  logic                 last_grant_data;  // 0 = fetch served last
  logic [CNT_WIDTH-1:0] cnt;
  logic                 grant_data, grant_fetch, done, timed_out;

  always_comb begin
    state_next  = state;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    timed_out   = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        // With both pending, data wins unless it was the last one served.
        if (d_req && (!if_req || !last_grant_data)) grant_data = 1'b1;
        else if (if_req)                            grant_fetch = 1'b1;
        if (grant_data)       state_next = DATA;
        else if (grant_fetch) state_next = FETCH;
      end
      FETCH, DATA: begin
        // Counter holds the number of ack-less cycles already elapsed.
        timed_out = !mem_ack && (cnt == CNT_WIDTH'(TIMEOUT - 1));
        done      = mem_ack || timed_out;
        if (done) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_mode        <= '0;
      if_rdata        <= '0;
      if_valid        <= 1'b0;
      d_rdata         <= '0;
      d_valid         <= 1'b0;
      err             <= 1'b0;
      cnt             <= '0;
      last_grant_data <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_mode  <= d_mode;
            cnt       <= '0;
          end else if (grant_fetch) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_mode  <= 2'b10;
            cnt       <= '0;
          end
        end
        FETCH, DATA: begin
          if (done) begin
            mem_req <= 1'b0;
            if (timed_out) err <= 1'b1;
            if (state == FETCH) begin
              if_valid <= 1'b1;
              if_rdata <= timed_out ? '0 : mem_rdata;
            end else begin
              d_valid <= 1'b1;
              if (!mem_we) d_rdata <= timed_out ? '0 : mem_rdata;
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        RESP: last_grant_data <= mem_we || (mem_mode != 2'b10) || d_valid;
        default: ;
      endcase
    end
  end

  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, if_valid, d_req, d_we, d_valid, stall;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [1:0]  d_mode, mem_mode;
  logic        mem_req, mem_we, mem_ack, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mode(d_mode),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mode(mem_mode), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Memory responder: waits (bounded) for mem_req, records the request
  // fields, then acks after wait_cyc extra cycles. Returns at the negedge
  // following the ack edge, i.e. in the RESP cycle.
  task automatic serve(input int wait_cyc, input logic [31:0] data, output bit ok,
                       output logic [31:0] a, output logic w, output logic [31:0] wd,
                       output logic [1:0] m);
    int n = 0;
    ok = 1'b0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    a = mem_addr; w = mem_we; wd = mem_wdata; m = mem_mode;
    if (mem_req) begin
      ok = 1'b1;
      repeat (wait_cyc) @(negedge clk);
      mem_ack = 1'b1;
      mem_rdata = data;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = '0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    tests++; if (mem_mode !== 2'b00) begin fails++; $display("FAIL rst_mem_mode: got %b expected 00", mem_mode); end
    tests++; if ({if_valid, d_valid, err} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b expected 000", {if_valid, d_valid, err}); end
    tests++; if (d_rdata !== 32'h0) begin fails++; $display("FAIL rst_d_rdata: got %h expected 0", d_rdata); end
  endtask

  task automatic test_fetch();
    bit ok; logic [31:0] a, wd; logic w; logic [1:0] m;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL fetch_stall_on: got %b expected 1", stall); end
    serve(3, 32'h00500093, ok, a, w, wd, m);
    tests++; if (!ok) begin fails++; $display("FAIL fetch_grant: got no mem_req expected mem_req"); end
    tests++; if (a !== 32'h100 || m !== 2'b10 || w !== 1'b0) begin fails++; $display("FAIL fetch_fields: got %h/%b/%b expected 00000100/10/0", a, m, w); end
    tests++; if (if_valid !== 1'b1 || if_rdata !== 32'h00500093) begin fails++; $display("FAIL fetch_data: got %b %h expected 1 00500093", if_valid, if_rdata); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fetch_stall_off: got %b expected 0", stall); end
    if_req = 1'b0;
    @(negedge clk);
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL fetch_pulse: got %b expected 0", if_valid); end
  endtask

  task automatic test_both();
    bit ok; logic [31:0] a, wd; logic w; logic [1:0] m;
    do_reset();
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_mode = 2'b10;
    serve(0, 32'h11111111, ok, a, w, wd, m);
    tests++; if (!ok || a !== 32'h2000) begin fails++; $display("FAIL both_first: got ok=%b %h expected 1 00002000", ok, a); end
    tests++; if (d_valid !== 1'b1 || d_rdata !== 32'h11111111 || if_valid !== 1'b0) begin fails++; $display("FAIL both_data: got %b %h %b expected 1 11111111 0", d_valid, d_rdata, if_valid); end
    d_req = 1'b0;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL both_stall: got %b expected 1", stall); end
    serve(1, 32'h22222222, ok, a, w, wd, m);
    tests++; if (!ok || a !== 32'h300 || m !== 2'b10) begin fails++; $display("FAIL both_second: got ok=%b %h %b expected 1 00000300 10", ok, a, m); end
    tests++; if (if_valid !== 1'b1 || if_rdata !== 32'h22222222 || stall !== 1'b0) begin fails++; $display("FAIL both_fetch: got %b %h stall=%b expected 1 22222222 0", if_valid, if_rdata, stall); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    bit ok; logic [31:0] a, wd; logic w; logic [1:0] m;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hCAFEBABE; d_mode = 2'b00;
    serve(1, 32'hDEADBEEF, ok, a, w, wd, m);
    tests++; if (!ok || a !== 32'h2004 || w !== 1'b1 || wd !== 32'hCAFEBABE || m !== 2'b00) begin fails++; $display("FAIL store_fields: got %h %b %h %b expected 00002004 1 cafebabe 00", a, w, wd, m); end
    tests++; if (d_valid !== 1'b1 || d_rdata !== 32'h11111111) begin fails++; $display("FAIL store_resp: got %b %h expected 1 11111111", d_valid, d_rdata); end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n = 0;
    int k = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_mode = 2'b10;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    while (mem_req && k < 20) begin @(negedge clk); k++; end
    tests++; if (k !== 4) begin fails++; $display("FAIL timeout_len: got %0d expected 4", k); end
    tests++; if (d_valid !== 1'b1 || d_rdata !== 32'h0 || err !== 1'b1) begin fails++; $display("FAIL timeout_resp: got %b %h err=%b expected 1 00000000 1", d_valid, d_rdata, err); end
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    tests++; if (err !== 1'b1 || d_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL timeout_sticky: got err=%b dv=%b req=%b expected 1 0 0", err, d_valid, mem_req); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    if_req = 1'b1; if_addr = 32'h500;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || err !== 1'b0) begin fails++; $display("FAIL rstmid_clear: got req=%b %h err=%b expected 0 0 0", mem_req, mem_addr, err); end
    rst = 1'b0; if_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hBAD;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    tests++; if (if_valid !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h0) begin fails++; $display("FAIL rstmid_ack: got v=%b req=%b %h expected 0 0 0", if_valid, mem_req, if_rdata); end
    @(negedge clk);
    tests++; if (if_valid !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got v=%b stall=%b expected 0 0", if_valid, stall); end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [31:0] a, wd; logic w; logic [1:0] m;
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    int prev = 0;
    addrs = '{32'h3000, 32'h3004, 32'h3008};
    datas = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
    d_we = 1'b0; d_mode = 2'b10; d_req = 1'b1; d_addr = addrs[0];
    for (int k = 0; k < 3; k++) begin
      serve(0, datas[k], ok, a, w, wd, m);
      tests++; if (!ok || a !== addrs[k]) begin fails++; $display("FAIL b2b_addr%0d: got %h expected %h", k, a, addrs[k]); end
      tests++; if (d_valid !== 1'b1 || d_rdata !== datas[k]) begin fails++; $display("FAIL b2b_data%0d: got %b %h expected 1 %h", k, d_valid, d_rdata, datas[k]); end
      if (k > 0) begin
        tests++; if (cyc - prev !== 3) begin fails++; $display("FAIL b2b_spacing%0d: got %0d expected 3", k, cyc - prev); end
      end
      prev = cyc;
      if (k < 2) begin
        d_addr = addrs[k+1];
        @(negedge clk);
        tests++; if (mem_addr !== addrs[k] || mem_req !== 1'b0) begin fails++; $display("FAIL b2b_hold%0d: got %h req=%b expected %h 0", k, mem_addr, mem_req, addrs[k]); end
      end
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit ok; logic [31:0] a, wd; logic w; logic [1:0] m;
    if_req = 1'b1; if_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_mode = 2'b10;
    serve(0, 32'h0000000A, ok, a, w, wd, m);
    tests++; if (!ok || a !== 32'h600 || if_valid !== 1'b1 || d_valid !== 1'b0) begin fails++; $display("FAIL rr_fetch_first: got %h iv=%b dv=%b expected 00000600 1 0", a, if_valid, d_valid); end
    if_req = 1'b0;
    serve(0, 32'h0000000B, ok, a, w, wd, m);
    tests++; if (!ok || a !== 32'h700 || d_valid !== 1'b1 || d_rdata !== 32'hB) begin fails++; $display("FAIL rr_data_second: got %h dv=%b %h expected 00000700 1 0000000b", a, d_valid, d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_mode = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_fetch();
    test_both();
    test_store();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
